// File: rtl/alu_load_seq.sv
// alu_load_seq
//   Front-end sequencer for the switch-driven ALU top. Two raw push buttons are
//   synchronised and debounced, then a four-state FSM (A -> B -> OP -> SHOW)
//   captures the switches on each "next" press. Each capture is paired with a
//   single load-enable pulse towards the operand/opcode registers of the top.
//   Opcodes are screened against the ALU's supported set before being loaded.
//
// Ports
//   i_clk       in   1        system clock
//   i_rst       in   1        asynchronous, active-high reset
//   i_btn_next  in   1        raw "next/load" button (asynchronous, active-high)
//   i_btn_clr   in   1        raw "clear" button (asynchronous, active-high)
//   i_sw        in   NB_DATA  raw slide switches
//   o_data      out  NB_DATA  switches captured at the accepted press
//   o_en_A      out  1        one-cycle load pulse for operand A
//   o_en_B      out  1        one-cycle load pulse for operand B
//   o_en_OP     out  1        one-cycle load pulse for the opcode
//   o_state     out  2        00=S_A, 01=S_B, 10=S_OP, 11=S_SHOW
//   o_valid     out  1        high while the ALU result reflects loaded A/B/OP
//   o_err       out  1        sticky: the last opcode attempt was illegal

// alu_load_seq_debounce
//   Synchroniser plus level debouncer for one button. Produces a one-cycle
//   strobe when the debounced level rises; release edges are ignored.
//
// Ports
//   clk, rst   clock and asynchronous active-high reset
//   btn        raw button level
//   press      one-cycle strobe on an accepted press
module alu_load_seq_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_BITS   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DB_CYCLES - 1);

    logic               sync_1;
    logic               sync_2;
    logic               stable;
    logic               stable_d;
    logic [DB_BITS-1:0] cnt;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any return to agreement restarts the qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            stable_d <= stable;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Rising edge of the accepted level; built only from registers.
    assign press = stable & ~stable_d;

endmodule

module alu_load_seq #(
    parameter int NB_DATA   = 8,
    parameter int NB_OP     = 6,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_BITS   = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_btn_next,
    input  logic               i_btn_clr,
    input  logic [NB_DATA-1:0] i_sw,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_en_A,
    output logic               o_en_B,
    output logic               o_en_OP,
    output logic [1:0]         o_state,
    output logic               o_valid,
    output logic               o_err
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    state_t state;
    logic   next_press;
    logic   clr_press;

    alu_load_seq_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_BITS   (DB_BITS)
    ) u_db_next (
        .clk   (i_clk),
        .rst   (i_rst),
        .btn   (i_btn_next),
        .press (next_press)
    );

    alu_load_seq_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_BITS   (DB_BITS)
    ) u_db_clr (
        .clk   (i_clk),
        .rst   (i_rst),
        .btn   (i_btn_clr),
        .press (clr_press)
    );

    // Opcodes the ALU implements: ADD, SUB, AND, OR, XOR, NOR, SRA, SRL.
    function automatic logic is_legal(input logic [NB_OP-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            NB_OP'(6'b100000),
            NB_OP'(6'b100010),
            NB_OP'(6'b100100),
            NB_OP'(6'b100101),
            NB_OP'(6'b100110),
            NB_OP'(6'b100111),
            NB_OP'(6'b000011),
            NB_OP'(6'b000010): ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Enables default low every cycle so each load is a single-cycle pulse
    // coinciding with the first cycle o_data carries the new value. Clear
    // wins over next when both strobes land together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_A;
            o_data  <= '0;
            o_en_A  <= 1'b0;
            o_en_B  <= 1'b0;
            o_en_OP <= 1'b0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_en_A  <= 1'b0;
            o_en_B  <= 1'b0;
            o_en_OP <= 1'b0;
            if (clr_press) begin
                state   <= S_A;
                o_valid <= 1'b0;
                o_err   <= 1'b0;
            end else if (next_press) begin
                case (state)
                    S_A: begin
                        o_data <= i_sw;
                        o_en_A <= 1'b1;
                        state  <= S_B;
                    end
                    S_B: begin
                        o_data <= i_sw;
                        o_en_B <= 1'b1;
                        state  <= S_OP;
                    end
                    S_OP: begin
                        if (is_legal(i_sw[NB_OP-1:0])) begin
                            o_data  <= i_sw;
                            o_en_OP <= 1'b1;
                            o_err   <= 1'b0;
                            o_valid <= 1'b1;
                            state   <= S_SHOW;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                    S_SHOW: begin
                        o_valid <= 1'b0;
                        state   <= S_A;
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alu_load_seq.sv
// tb_alu_load_seq
//   Self-checking bench for alu_load_seq with a short debounce window.
//   A press-level reference model tracks the expected phase, captured data,
//   valid and error flags; every button press is compared against it.
module tb_alu_load_seq;

    localparam int NB_DATA   = 8;
    localparam int NB_OP     = 6;
    localparam int DB_CYCLES = 4;
    localparam int DB_BITS   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               btn_next;
    logic               btn_clr;
    logic [NB_DATA-1:0] sw;
    logic [NB_DATA-1:0] o_data;
    logic               o_en_A;
    logic               o_en_B;
    logic               o_en_OP;
    logic [1:0]         o_state;
    logic               o_valid;
    logic               o_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0..3 = collecting A, B, opcode, showing.
    int         m_state;
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_err;

    logic [5:0] legal_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    alu_load_seq #(
        .NB_DATA   (NB_DATA),
        .NB_OP     (NB_OP),
        .DB_CYCLES (DB_CYCLES),
        .DB_BITS   (DB_BITS)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_next (btn_next),
        .i_btn_clr  (btn_clr),
        .i_sw       (sw),
        .o_data     (o_data),
        .o_en_A     (o_en_A),
        .o_en_B     (o_en_B),
        .o_en_OP    (o_en_OP),
        .o_state    (o_state),
        .o_valid    (o_valid),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal(input logic [7:0] s);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++)
            if (s[5:0] == legal_ops[i]) ok = 1'b1;
        return ok;
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_press(input logic [7:0] s, input bit nxt, input bit clr,
                               output int ea, output int eb, output int eop);
        ea = 0; eb = 0; eop = 0;
        if (clr) begin
            m_state = 0; m_valid = 1'b0; m_err = 1'b0;
        end else if (nxt) begin
            case (m_state)
                0: begin m_data = s; ea = 1; m_state = 1; end
                1: begin m_data = s; eb = 1; m_state = 2; end
                2: begin
                    if (ref_legal(s)) begin
                        m_data = s; eop = 1; m_err = 1'b0; m_valid = 1'b1; m_state = 3;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                default: begin m_valid = 1'b0; m_state = 0; end
            endcase
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; btn_next = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Holds the chosen buttons for 12 cycles, releases, lets the release
    // settle, and records every enable pulse seen on the way.
    task automatic do_press(input logic [7:0] s, input bit nxt, input bit clr,
                            output int na, output int nb, output int nop,
                            output int lat, output int ovl, output logic [7:0] pd);
        int n;
        na = 0; nb = 0; nop = 0; lat = -1; ovl = 0; pd = 8'h00;
        @(negedge clk);
        sw = s; btn_next = nxt; btn_clr = clr;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            n = int'(o_en_A) + int'(o_en_B) + int'(o_en_OP);
            if (n > 1) ovl++;
            if (o_en_A) na++;
            if (o_en_B) nb++;
            if (o_en_OP) nop++;
            if (n > 0) begin
                pd = o_data;
                if (lat < 0) lat = c;
            end
            if (c == 12) begin btn_next = 1'b0; btn_clr = 1'b0; end
        end
    endtask

    task automatic run_step(input logic [7:0] s, input bit nxt, input bit clr,
                            output logic [27:0] obs, output logic [27:0] exp,
                            output int lat, output bit pulse_exp);
        int na, nb, nop, ovl, ea, eb, eop;
        logic [7:0] pd;
        do_press(s, nxt, clr, na, nb, nop, lat, ovl, pd);
        model_press(s, nxt, clr, ea, eb, eop);
        pulse_exp = (ea + eb + eop) != 0;
        obs = {sat2(na), sat2(nb), sat2(nop), sat2(ovl), pd,
               o_data, o_state, o_valid, o_err};
        exp = {2'(ea), 2'(eb), 2'(eop), 2'd0, pulse_exp ? m_data : 8'h00,
               m_data, 2'(m_state), m_valid, m_err};
    endtask

    task automatic test_reset();
        int pulses;
        @(negedge clk);
        rst = 1'b1; btn_next = 1'b0; btn_clr = 1'b0; sw = 8'hA5;
        #1;
        checks++;
        if ({o_data, o_state, o_valid, o_err, o_en_A, o_en_B, o_en_OP} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got data=%h state=%b valid=%b err=%b en=%b%b%b want all zero",
                     o_data, o_state, o_valid, o_err, o_en_A, o_en_B, o_en_OP);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            pulses += int'(o_en_A) + int'(o_en_B) + int'(o_en_OP);
        end
        checks++;
        if (pulses != 0 || o_state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got pulses=%0d state=%b want 0 and 00", pulses, o_state);
        end
    endtask

    task automatic test_load_sequence();
        logic [7:0] vals [3] = '{8'h05, 8'h03, 8'h20};
        logic [27:0] obs, exp;
        int lat;
        bit pe;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            run_step(vals[i], 1'b1, 1'b0, obs, exp, lat, pe);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL load_step%0d: got %h want %h", i, obs, exp);
            end
            checks++;
            if (lat < DB_CYCLES + 2 || lat > DB_CYCLES + 4) begin
                errors++;
                $display("[TB] FAIL load_latency%0d: got %0d want %0d..%0d",
                         i, lat, DB_CYCLES + 2, DB_CYCLES + 4);
            end
        end
    endtask

    task automatic test_bounce();
        int bounce_pulses, hold_pulses, lat;
        int ea, eb, eop;
        apply_reset();
        sw = 8'h6C;
        bounce_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            btn_next = ((c % 4) < 2);
            @(negedge clk);
            bounce_pulses += int'(o_en_A) + int'(o_en_B) + int'(o_en_OP);
        end
        btn_next = 1'b1;
        hold_pulses = 0; lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_en_A) begin
                hold_pulses++;
                if (lat < 0) lat = c;
            end
        end
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
        model_press(8'h6C, 1'b1, 1'b0, ea, eb, eop);
        checks++;
        if (bounce_pulses != 0 || hold_pulses != 1) begin
            errors++;
            $display("[TB] FAIL bounce_pulses: got bounce=%0d hold=%0d want 0 and 1",
                     bounce_pulses, hold_pulses);
        end
        checks++;
        if (lat < DB_CYCLES + 2 || lat > DB_CYCLES + 4) begin
            errors++;
            $display("[TB] FAIL bounce_latency: got %0d want %0d..%0d", lat, DB_CYCLES + 2, DB_CYCLES + 4);
        end
        checks++;
        if ({o_data, o_state} !== {m_data, 2'(m_state)}) begin
            errors++;
            $display("[TB] FAIL bounce_state: got data=%h state=%b want data=%h state=%b",
                     o_data, o_state, m_data, 2'(m_state));
        end
    endtask

    task automatic test_illegal_opcode();
        logic [7:0] vals [4] = '{8'h12, 8'h34, 8'h3F, 8'h22};
        logic [27:0] obs, exp;
        int lat;
        bit pe;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_step(vals[i], 1'b1, 1'b0, obs, exp, lat, pe);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL opcode_step%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_clr_priority();
        logic [27:0] obs, exp;
        int lat;
        bit pe;
        apply_reset();
        run_step(8'h11, 1'b1, 1'b0, obs, exp, lat, pe);
        run_step(8'h44, 1'b1, 1'b1, obs, exp, lat, pe);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL clr_with_next: got %h want %h", obs, exp);
        end
        run_step(8'h11, 1'b1, 1'b0, obs, exp, lat, pe);
        run_step(8'h22, 1'b1, 1'b0, obs, exp, lat, pe);
        run_step(8'h01, 1'b1, 1'b0, obs, exp, lat, pe);
        run_step(8'h00, 1'b0, 1'b1, obs, exp, lat, pe);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL clr_clears_err: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [27:0] obs, exp;
        int lat, pulses_a, pulses_other;
        int ea, eb, eop;
        bit pe;
        apply_reset();
        run_step(8'h05, 1'b1, 1'b0, obs, exp, lat, pe);
        run_step(8'h03, 1'b1, 1'b0, obs, exp, lat, pe);
        @(negedge clk);
        sw = 8'h22; btn_next = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_data, o_state, o_valid, o_err, o_en_A, o_en_B, o_en_OP} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got data=%h state=%b valid=%b err=%b en=%b%b%b want all zero",
                     o_data, o_state, o_valid, o_err, o_en_A, o_en_B, o_en_OP);
        end
        btn_next = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        run_step(8'h5A, 1'b1, 1'b0, obs, exp, lat, pe);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL after_async_reset: got %h want %h", obs, exp);
        end
        // Button held across reset release must still register as one press.
        @(negedge clk);
        rst = 1'b1; btn_next = 1'b1; sw = 8'h77;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses_a = 0; pulses_other = 0;
        repeat (20) begin
            @(negedge clk);
            pulses_a += int'(o_en_A);
            pulses_other += int'(o_en_B) + int'(o_en_OP);
        end
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
        model_press(8'h77, 1'b1, 1'b0, ea, eb, eop);
        checks++;
        if (pulses_a != 1 || pulses_other != 0 || o_data !== m_data || o_state !== 2'(m_state)) begin
            errors++;
            $display("[TB] FAIL held_through_reset: got A=%0d other=%0d data=%h state=%b want 1 0 %h %b",
                     pulses_a, pulses_other, o_data, o_state, m_data, 2'(m_state));
        end
    endtask

    task automatic test_show_restart();
        logic [7:0] vals [5] = '{8'h05, 8'h03, 8'h20, 8'h99, 8'hFF};
        logic [27:0] obs, exp;
        int lat;
        bit pe;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_step(vals[i], 1'b1, 1'b0, obs, exp, lat, pe);
            if (i >= 2) begin
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL show_step%0d: got %h want %h", i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [27:0] obs, exp;
        logic [7:0] s;
        int lat;
        bit pe, use_clr;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            s = 8'($urandom);
            if (m_state == 2 && $urandom_range(1, 0) == 1)
                s[5:0] = legal_ops[$urandom_range(7, 0)];
            use_clr = ($urandom_range(7, 0) == 0);
            run_step(s, !use_clr, use_clr, obs, exp, lat, pe);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL random_step%0d sw=%h: got %h want %h", i, s, obs, exp);
            end
            if (pe) begin
                checks++;
                if (lat < DB_CYCLES + 2 || lat > DB_CYCLES + 4) begin
                    errors++;
                    $display("[TB] FAIL random_latency%0d: got %0d want %0d..%0d",
                             i, lat, DB_CYCLES + 2, DB_CYCLES + 4);
                end
            end
        end
    endtask

    // Scenarios run back to back; each begins from its own reset.
    initial begin
        rst = 1'b0; btn_next = 1'b0; btn_clr = 1'b0; sw = 8'h00;
        model_reset();
        test_reset();
        test_load_sequence();
        test_bounce();
        test_illegal_opcode();
        test_clr_priority();
        test_async_reset();
        test_show_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
